adc0808_scan_controller: RTL and testbench

Sequencer for the external ADC0808. It walks the enabled analog channels in round-robin order and drives the ALE/START/OE/address control pins with programmable system-clock timing. It waits on EOC with a timeout and emits one tagged 8-bit sample per conversion. It sits between the board pins and the downstream consumers of the converted data: the BCD/display path and a per-channel result store.

---
 rtl/adc_pkg.sv | 37 +++
 rtl/rr_next_channel.sv | 33 +++
 rtl/adc0808_scan_controller.sv | 180 ++++++++++++++++++
 tb/tb_adc0808_scan_controller.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// adc_pkg: shared definitions for the ADC0808 scan controller.
//   - state_t       : sequencer states
//   - NUM_CH / CH_W : analog channel count and index width
//   - CNT_W         : phase timing counter width
//   - DEF_*         : default phase timings in system-clock cycles
//   - cnt_load()    : counter preset so a phase of N cycles ends on count 0
package adc_pkg;

    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;
    localparam int CNT_W  = 16;

    localparam int unsigned DEF_ADDR_SETUP   = 20;
    localparam int unsigned DEF_ALE_CYCLES   = 50;
    localparam int unsigned DEF_START_CYCLES = 50;
    localparam int unsigned DEF_EOC_FALL_MAX = 1000;
    localparam int unsigned DEF_EOC_TIMEOUT  = 20000;
    localparam int unsigned DEF_OE_SETTLE    = 20;
    localparam int unsigned DEF_GAP_CYCLES   = 100;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SETUP,
        ST_ALE,
        ST_START,
        ST_WAIT_LO,
        ST_WAIT_HI,
        ST_READ,
        ST_GAP
    } state_t;

    function automatic logic [CNT_W-1:0] cnt_load(input int unsigned n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/rr_next_channel.sv
// rr_next_channel: combinational round-robin channel pick.
//   i_ptr   : last channel served
//   i_mask  : enabled channels
//   o_idx   : first enabled channel strictly after i_ptr, wrapping 7->0
//             (i_ptr itself when it is the only enabled channel)
//   o_found : at least one channel is enabled
module rr_next_channel
    import adc_pkg::*;
(
    input  logic [CH_W-1:0]   i_ptr,
    input  logic [NUM_CH-1:0] i_mask,
    output logic [CH_W-1:0]   o_idx,
    output logic              o_found
);

    logic [CH_W-1:0] w_cand;

    // Walk from the farthest candidate (the pointer itself, offset NUM_CH)
    // down to the nearest (offset 1) so the nearest enabled one wins.
    always_comb begin
        o_idx   = i_ptr;
        o_found = 1'b0;
        w_cand  = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            w_cand = i_ptr + CH_W'(k);
            if (i_mask[w_cand]) begin
                o_idx   = w_cand;
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc0808_scan_controller.sv
// adc0808_scan_controller: round-robin conversion sequencer for an ADC0808.
//   CLK100MHZ    : system clock
//   reset        : asynchronous active-low reset
//   scan_en      : run conversions continuously while high
//   chan_en      : channel enable mask, sampled at each channel pick
//   eoc          : ADC end-of-conversion (asynchronous, synchronized here)
//   data_in      : ADC parallel data
//   ale/start/oe : ADC control pins
//   addr         : ADC channel select
//   sample_data  : last captured result, sample_chan its channel
//   sample_valid : one-cycle pulse per new sample
//   timeout_err  : one-cycle pulse per aborted conversion
//   busy         : high whenever not idle
// All outputs are registered from the next state so pins never glitch on
// state decode and each phase's pins line up with the phase cycles exactly.
module adc0808_scan_controller
    import adc_pkg::*;
#(
    parameter int unsigned ADDR_SETUP   = DEF_ADDR_SETUP,
    parameter int unsigned ALE_CYCLES   = DEF_ALE_CYCLES,
    parameter int unsigned START_CYCLES = DEF_START_CYCLES,
    parameter int unsigned EOC_FALL_MAX = DEF_EOC_FALL_MAX,
    parameter int unsigned EOC_TIMEOUT  = DEF_EOC_TIMEOUT,
    parameter int unsigned OE_SETTLE    = DEF_OE_SETTLE,
    parameter int unsigned GAP_CYCLES   = DEF_GAP_CYCLES
) (
    input  logic              CLK100MHZ,
    input  logic              reset,
    input  logic              scan_en,
    input  logic [NUM_CH-1:0] chan_en,
    input  logic              eoc,
    input  logic [7:0]        data_in,
    output logic              ale,
    output logic              start,
    output logic              oe,
    output logic [CH_W-1:0]   addr,
    output logic [7:0]        sample_data,
    output logic [CH_W-1:0]   sample_chan,
    output logic              sample_valid,
    output logic              timeout_err,
    output logic              busy
);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CH_W-1:0]  r_ptr, r_addr, r_sample_chan;
    logic [7:0]       r_sample_data;
    logic             r_eoc_meta, r_eoc_sync;
    logic             r_ale, r_start, r_oe, r_valid, r_timeout, r_busy;
    logic [CH_W-1:0]  w_pick_idx;
    logic             w_pick_found;
    logic             w_cnt_done;
    logic             w_capture;
    logic             w_timeout;

    rr_next_channel u_rr (
        .i_ptr   (r_ptr),
        .i_mask  (chan_en),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    assign w_cnt_done = (r_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_done ? r_cnt : r_cnt - 1'b1;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (scan_en && (|chan_en)) w_state_nxt = ST_SELECT;
            end
            ST_SELECT: begin
                if (w_pick_found) begin
                    w_state_nxt = ST_SETUP;
                    w_cnt_nxt   = cnt_load(ADDR_SETUP);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (w_cnt_done) begin
                    w_state_nxt = ST_ALE;
                    w_cnt_nxt   = cnt_load(ALE_CYCLES);
                end
            end
            ST_ALE: begin
                if (w_cnt_done) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = cnt_load(START_CYCLES);
                end
            end
            ST_START: begin
                if (w_cnt_done) begin
                    w_state_nxt = ST_WAIT_LO;
                    w_cnt_nxt   = cnt_load(EOC_FALL_MAX);
                end
            end
            ST_WAIT_LO: begin
                // A conversion fast enough to hide the eoc low pulse still
                // moves on once the fall window expires.
                if (!r_eoc_sync || w_cnt_done) begin
                    w_state_nxt = ST_WAIT_HI;
                    w_cnt_nxt   = cnt_load(EOC_TIMEOUT);
                end
            end
            ST_WAIT_HI: begin
                if (r_eoc_sync) begin
                    w_state_nxt = ST_READ;
                    w_cnt_nxt   = cnt_load(OE_SETTLE);
                end else if (w_cnt_done) begin
                    w_state_nxt = ST_GAP;
                    w_cnt_nxt   = cnt_load(GAP_CYCLES);
                    w_timeout   = 1'b1;
                end
            end
            ST_READ: begin
                if (w_cnt_done) begin
                    w_state_nxt = ST_GAP;
                    w_cnt_nxt   = cnt_load(GAP_CYCLES);
                    w_capture   = 1'b1;
                end
            end
            ST_GAP: begin
                if (w_cnt_done) w_state_nxt = scan_en ? ST_SELECT : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_ptr         <= CH_W'(NUM_CH - 1);
            r_addr        <= '0;
            r_eoc_meta    <= 1'b0;
            r_eoc_sync    <= 1'b0;
            r_ale         <= 1'b0;
            r_start       <= 1'b0;
            r_oe          <= 1'b0;
            r_busy        <= 1'b0;
            r_valid       <= 1'b0;
            r_timeout     <= 1'b0;
            r_sample_data <= '0;
            r_sample_chan <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_eoc_meta <= eoc;
            r_eoc_sync <= r_eoc_meta;
            if (r_state == ST_SELECT && w_pick_found) begin
                r_ptr  <= w_pick_idx;
                r_addr <= w_pick_idx;
            end
            r_ale     <= (w_state_nxt == ST_ALE) || (w_state_nxt == ST_START);
            r_start   <= (w_state_nxt == ST_START);
            r_oe      <= (w_state_nxt == ST_READ);
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_valid   <= w_capture;
            r_timeout <= w_timeout;
            if (w_capture) begin
                r_sample_data <= data_in;
                r_sample_chan <= r_addr;
            end
        end
    end

    assign ale          = r_ale;
    assign start        = r_start;
    assign oe           = r_oe;
    assign addr         = r_addr;
    assign busy         = r_busy;
    assign sample_valid = r_valid;
    assign timeout_err  = r_timeout;
    assign sample_data  = r_sample_data;
    assign sample_chan  = r_sample_chan;

endmodule

// File: tb/tb_adc0808_scan_controller.sv
// Bench for adc0808_scan_controller. A single process plays the ADC and the
// host, and walks each conversion as a timeline of phase lengths computed
// from the timing rules; every cycle it compares all outputs on the falling
// edge. eoc is scheduled relative to the first cycle after start falls.
module tb_adc0808_scan_controller;

    localparam int P_SETUP = 20, P_ALE = 50, P_START = 50, P_FALL = 1000;
    localparam int P_TO = 20000, P_OE = 20, P_GAP = 100;
    localparam int NEVER = 32'h3fff_ffff;
    localparam int H_NONE = 0, H_MASK = 1, H_DROP = 2, H_ZERO = 3, H_RST = 4;

    logic       clk = 1'b0;
    logic       rst_n, scan_en, eoc;
    logic [7:0] chan_en, data_in;
    logic       ale, start, oe, sample_valid, timeout_err, busy;
    logic [2:0] addr, sample_chan;
    logic [7:0] sample_data;

    int n_chk = 0, n_err = 0, gt = 0, lo_at = 0, hi_at = 0;
    logic [2:0] m_ptr = 3'd7, m_addr = 3'd0, m_chan = 3'd0;
    logic [7:0] m_data = 8'h00;

    adc0808_scan_controller #(
        .ADDR_SETUP(P_SETUP), .ALE_CYCLES(P_ALE), .START_CYCLES(P_START),
        .EOC_FALL_MAX(P_FALL), .EOC_TIMEOUT(P_TO), .OE_SETTLE(P_OE),
        .GAP_CYCLES(P_GAP)
    ) dut (
        .CLK100MHZ(clk), .reset(rst_n), .scan_en(scan_en), .chan_en(chan_en),
        .eoc(eoc), .data_in(data_in), .ale(ale), .start(start), .oe(oe),
        .addr(addr), .sample_data(sample_data), .sample_chan(sample_chan),
        .sample_valid(sample_valid), .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, gt, act, exp);
        end
    endtask

    // One cycle: compare every output, then drive eoc for the next cycle.
    task automatic obs(input logic e_ale, e_start, e_oe, e_busy, e_vld, e_to);
        @(negedge clk);
        chk("ale", 16'(ale), 16'(e_ale));
        chk("start", 16'(start), 16'(e_start));
        chk("oe", 16'(oe), 16'(e_oe));
        chk("busy", 16'(busy), 16'(e_busy));
        chk("sample_valid", 16'(sample_valid), 16'(e_vld));
        chk("timeout_err", 16'(timeout_err), 16'(e_to));
        chk("addr", 16'(addr), 16'(m_addr));
        chk("sample_data", 16'(sample_data), 16'(m_data));
        chk("sample_chan", 16'(sample_chan), 16'(m_chan));
        gt++;
        eoc = (gt >= lo_at && gt < hi_at) ? 1'b0 : 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) obs(0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [2:0] rr(input logic [2:0] p, input logic [7:0] m);
        for (int k = 1; k <= 8; k++) begin
            int c;
            c = (int'(p) + k) % 8;
            if (m[c]) return 3'(c);
        end
        return p;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_ale", 16'(ale), 16'd0);
        chk("rst_start", 16'(start), 16'd0);
        chk("rst_oe", 16'(oe), 16'd0);
        chk("rst_addr", 16'(addr), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        m_ptr = 3'd7; m_addr = 3'd0; m_data = 8'h00; m_chan = 3'd0;
        lo_at = 0; hi_at = 0;
        idle(3);
        rst_n = 1'b1;
    endtask

    // Timeline of one conversion starting at its SELECT cycle. eoc goes low
    // a cycles and high again b cycles after the first post-start cycle.
    task automatic conv(input int a, input int b, input logic [7:0] din,
                        input int hook, input logic [7:0] hmask, output logic went);
        int   n_lo, n_hi;
        logic to;
        obs(0, 0, 0, 1, 0, 0);
        went = (chan_en != 8'h00);
        if (!went) return;
        m_ptr  = rr(m_ptr, chan_en);
        m_addr = m_ptr;
        data_in = din;
        repeat (P_SETUP) obs(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < P_ALE; i++) begin
            obs(1, 0, 0, 1, 0, 0);
            if (hook == H_MASK && i == 0) chan_en = hmask;
        end
        repeat (P_START) obs(1, 1, 0, 1, 0, 0);
        lo_at = gt + 1 + a;
        hi_at = gt + 1 + b;
        // Two synchronizer flops plus the decision cycle: a level set after
        // cycle t steers the phase change visible at cycle t+3.
        if (a + 3 > P_FALL) begin n_lo = P_FALL; n_hi = 1; end
        else begin n_lo = a + 3; n_hi = b - a; end
        to = (n_hi > P_TO);
        repeat (n_lo) obs(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < (to ? P_TO : n_hi); i++) begin
            obs(0, 0, 0, 1, 0, 0);
            if (hook == H_DROP && i == 0) scan_en = 1'b0;
        end
        lo_at = 0; hi_at = 0;
        if (!to) begin
            for (int i = 0; i < P_OE; i++) begin
                obs(0, 0, 1, 1, 0, 0);
                if (hook == H_RST && i == 1) begin do_reset(); return; end
            end
            m_data = din;
            m_chan = m_addr;
        end
        obs(0, 0, 0, 1, !to, to);
        if (hook == H_ZERO) chan_en = 8'h00;
        repeat (P_GAP - 1) obs(0, 0, 0, 1, 0, 0);
    endtask

    initial begin
        logic       went;
        logic [7:0] m;
        logic [2:0] seq [5];
        int         a;
        seq = '{3'd2, 3'd5, 3'd7, 3'd2, 3'd5};
        rst_n = 1'b0; scan_en = 1'b0; chan_en = 8'h00; eoc = 1'b1; data_in = 8'h00;
        idle(3);
        scan_en = 1'b1; chan_en = 8'h01;
        idle(1);
        rst_n = 1'b1;

        // Single channel, eoc latency 200.
        repeat (2) begin
            conv(5, 200, 8'hA5, H_NONE, 8'h00, went);
            chk("ch0_chan", 16'(sample_chan), 16'd0);
            chk("ch0_data", 16'(sample_data), 16'h00A5);
        end

        // Round robin over channels 2, 5, 7.
        chan_en = 8'b1010_0100;
        for (int i = 0; i < 5; i++) begin
            conv(3, 150, 8'(i + 8'h10), H_NONE, 8'h00, went);
            chk("rr_seq", 16'(sample_chan), 16'(seq[i]));
        end

        // Random masks (changed mid-conversion), eoc timing and data.
        repeat (15) begin
            m = 8'($urandom_range(1, 255));
            if ($urandom_range(0, 3) == 0) m = 8'(1 << $urandom_range(0, 7));
            a = int'($urandom_range(0, 30));
            conv(a, a + 1 + int'($urandom_range(0, 300)), 8'($urandom), H_MASK, m, went);
        end

        // eoc never falls: fall window expires and the high level is read.
        chan_en = 8'h18;
        conv(NEVER, NEVER, 8'h3C, H_NONE, 8'h00, went);
        chk("eoc_high_data", 16'(sample_data), 16'h003C);
        // eoc never rises: timeout, previous sample held, next channel runs.
        conv(0, NEVER, 8'h77, H_NONE, 8'h00, went);
        chk("timeout_hold", 16'(sample_data), 16'h003C);
        conv(4, 100, 8'h11, H_NONE, 8'h00, went);
        chk("after_timeout", 16'(sample_data), 16'h0011);

        // scan_en dropped in WAIT_HI: sample still completes, then idle.
        conv(5, 150, 8'h22, H_DROP, 8'h00, went);
        chk("drop_data", 16'(sample_data), 16'h0022);
        idle(5);
        chk("drop_idle_busy", 16'(busy), 16'd0);

        // Mask cleared during GAP: one SELECT cycle then back to idle.
        scan_en = 1'b1;
        conv(5, 150, 8'h33, H_ZERO, 8'h00, went);
        conv(0, 0, 8'h00, H_NONE, 8'h00, went);
        idle(4);
        chk("zero_mask_busy", 16'(busy), 16'd0);

        // Mask 01 -> 80 during a channel-0 conversion.
        chan_en = 8'h01;
        conv(5, 120, 8'h44, H_MASK, 8'h80, went);
        chk("mask_chg_cur", 16'(sample_chan), 16'd0);
        conv(5, 120, 8'h55, H_NONE, 8'h00, went);
        chk("mask_chg_next", 16'(sample_chan), 16'd7);

        // Reset during READ of channel 2; scan restarts at channel 0, not 3.
        chan_en = 8'h0D;
        conv(5, 120, 8'h66, H_NONE, 8'h00, went);
        conv(5, 120, 8'h99, H_RST, 8'h00, went);
        conv(5, 120, 8'h5A, H_NONE, 8'h00, went);
        chk("post_rst_chan", 16'(sample_chan), 16'd0);
        chk("post_rst_data", 16'(sample_data), 16'h005A);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
